// File: rtl/unary_stream_encoder_pkg.sv
// Shared types and helpers for the streaming unary (level-code) encoder.
package unary_encoder_pkg;

    // Code style applied to the stored level.
    typedef enum logic [1:0] {
        UNARY_THERMO     = 2'd0,
        UNARY_THERMO_INV = 2'd1,
        UNARY_ONEHOT     = 2'd2,
        UNARY_RSVD       = 2'd3
    } unary_mode_e;

    // Burst controller states.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Width of the chunk index; a single-chunk code still gets a 1-bit index.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/unary_stream_encoder_if.sv
// Input handshake plus chunked output stream of the unary encoder.
// Signal names are as seen from the encoder (the slave side).
interface unary_stream_encoder_if #(
    parameter int INPUT_WIDTH = 7,
    parameter int CHUNK_WIDTH = 32,
    parameter int IDX_WIDTH   = 2
);
    import unary_encoder_pkg::*;

    logic                   valid_i;
    logic                   ready_o;
    logic [INPUT_WIDTH-1:0] value_i;
    unary_mode_e            mode_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [CHUNK_WIDTH-1:0] chunk_o;
    logic [IDX_WIDTH-1:0]   chunk_idx_o;
    logic                   last_o;

    // Encoder side.
    modport slave (
        input  valid_i, value_i, mode_i, ready_i,
        output ready_o, valid_o, chunk_o, chunk_idx_o, last_o
    );

    // Producer/consumer side.
    modport master (
        output valid_i, value_i, mode_i, ready_i,
        input  ready_o, valid_o, chunk_o, chunk_idx_o, last_o
    );

endinterface

// File: rtl/unary_stream_encoder_chunk_gen.sv
// Combinational generator for one CHUNK_WIDTH slice of the level code.
// Each output bit compares its absolute code position against the
// saturated level, so the full code vector never exists in hardware.
module unary_chunk_gen
    import unary_encoder_pkg::*;
#(
    parameter int INPUT_WIDTH  = 7,
    parameter int OUTPUT_WIDTH = 128,
    parameter int CHUNK_WIDTH  = 32,
    parameter int IDX_WIDTH    = 2
) (
    input  logic [INPUT_WIDTH-1:0] value,
    input  unary_mode_e            mode,
    input  logic [IDX_WIDTH-1:0]   idx,
    output logic [CHUNK_WIDTH-1:0] chunk
);
    // Wide enough for both the raw value (plus one) and any code position.
    localparam int OW_BITS = $clog2(OUTPUT_WIDTH) + 1;
    localparam int CMP_W   = (INPUT_WIDTH + 1 > OW_BITS) ? INPUT_WIDTH + 1 : OW_BITS;

    localparam logic [CMP_W-1:0] MAX_LEVEL  = CMP_W'(OUTPUT_WIDTH - 1);
    localparam logic [CMP_W-1:0] CHUNK_STEP = CMP_W'(CHUNK_WIDTH);

    logic [CMP_W-1:0] value_ext;
    logic [CMP_W-1:0] level;
    logic [CMP_W-1:0] base;

    assign value_ext = CMP_W'(value);
    // Values past the end of the code clamp to the top position.
    assign level     = (value_ext > MAX_LEVEL) ? MAX_LEVEL : value_ext;
    assign base      = CMP_W'(idx) * CHUNK_STEP;

    generate
        for (genvar gi = 0; gi < CHUNK_WIDTH; gi++) begin : g_bit
            localparam logic [CMP_W-1:0] BIT_OFS = CMP_W'(gi);
            logic [CMP_W-1:0] pos;
            assign pos = base + BIT_OFS;

            // Select this bit's value according to the code style.
            always_comb begin
                chunk[gi] = 1'b0;
                case (mode)
                    UNARY_THERMO:     chunk[gi] = (pos <= level);
                    UNARY_THERMO_INV: chunk[gi] = !(pos <= level);
                    UNARY_ONEHOT:     chunk[gi] = (pos == level);
                    default:          chunk[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/unary_stream_encoder.sv
// Streaming unary encoder: accepts one level per handshake and emits its
// OUTPUT_WIDTH-bit code as NUM_CHUNKS beats. Only value and mode are stored;
// each beat is regenerated from them and the chunk index.
module unary_stream_encoder
    import unary_encoder_pkg::*;
#(
    parameter int INPUT_WIDTH  = 7,
    parameter int OUTPUT_WIDTH = 2 ** INPUT_WIDTH,
    parameter int CHUNK_WIDTH  = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    unary_stream_encoder_if.slave bus
);
    // OUTPUT_WIDTH must be a non-zero multiple of CHUNK_WIDTH.
    localparam int NUM_CHUNKS = OUTPUT_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_e                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [INPUT_WIDTH-1:0] value_reg, value_next;
    unary_mode_e            mode_reg, mode_next;

    logic                   emit_valid;
    logic                   is_last;
    logic                   last_accept;
    logic                   in_ready;
    logic                   in_accept;
    logic [CHUNK_WIDTH-1:0] gen_chunk;

    assign emit_valid  = (state_reg == EMIT);
    assign is_last     = emit_valid && (idx_reg == LAST_IDX);
    assign last_accept = is_last && bus.ready_i;
    // Ready during the accepted last beat lets a new level follow with no
    // bubble; clear drops anything offered in the same cycle.
    assign in_ready    = !clear_i && ((state_reg == IDLE) || last_accept);
    assign in_accept   = bus.valid_i && in_ready;

    // Next-state, index and operand capture for the burst controller.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        value_next = value_reg;
        mode_next  = mode_reg;
        if (clear_i) begin
            state_next = IDLE;
            idx_next   = '0;
            value_next = '0;
            mode_next  = UNARY_THERMO;
        end else if (in_accept) begin
            state_next = EMIT;
            idx_next   = '0;
            value_next = bus.value_i;
            mode_next  = bus.mode_i;
        end else if (emit_valid && bus.ready_i) begin
            if (is_last) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                idx_next = idx_reg + IDX_W'(1);
            end
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            value_reg <= '0;
            mode_reg  <= UNARY_THERMO;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            value_reg <= value_next;
            mode_reg  <= mode_next;
        end
    end

    unary_chunk_gen #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .CHUNK_WIDTH  (CHUNK_WIDTH),
        .IDX_WIDTH    (IDX_W)
    ) u_chunk_gen (
        .value (value_reg),
        .mode  (mode_reg),
        .idx   (idx_reg),
        .chunk (gen_chunk)
    );

    assign bus.ready_o     = in_ready;
    assign bus.valid_o     = emit_valid;
    assign bus.last_o      = is_last;
    assign bus.chunk_idx_o = idx_reg;
    // Chunk is zero whenever no beat is being offered.
    assign bus.chunk_o     = emit_valid ? gen_chunk : '0;

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Self-checking bench: default 128-bit/4-chunk encoder plus a 64-bit/2-chunk
// encoder, checked against a whole-vector arithmetic reference model.
module tb_unary_stream_encoder;
    import unary_encoder_pkg::*;

    localparam int NCH_A = 4;
    localparam int NCH_B = 2;

    logic clk = 1'b0;
    logic rst;
    logic clear_a;
    logic clear_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    unary_stream_encoder_if #(.INPUT_WIDTH(7), .CHUNK_WIDTH(32), .IDX_WIDTH(2)) bus_a ();
    unary_stream_encoder_if #(.INPUT_WIDTH(7), .CHUNK_WIDTH(32), .IDX_WIDTH(1)) bus_b ();

    unary_stream_encoder #(.INPUT_WIDTH(7), .OUTPUT_WIDTH(128), .CHUNK_WIDTH(32)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear_a),
        .bus     (bus_a.slave)
    );

    unary_stream_encoder #(.INPUT_WIDTH(7), .OUTPUT_WIDTH(64), .CHUNK_WIDTH(32)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear_b),
        .bus     (bus_b.slave)
    );

    // Reference: build the whole code with arithmetic, then slice one chunk.
    function automatic logic [31:0] ref_chunk(input int value, input int mode, input int idx, input int ow);
        logic [255:0] ones;
        logic [255:0] code;
        int           v;
        v    = (value > ow - 1) ? ow - 1 : value;
        ones = (256'd1 << (v + 1)) - 256'd1;
        case (mode)
            0:       code = ones;
            1:       code = ~ones;
            2:       code = 256'd1 << v;
            default: code = '0;
        endcase
        return code[idx*32 +: 32];
    endfunction

    // Drive one burst on encoder A; optionally chain a new input on the last beat.
    task automatic run_burst(input string tag, input int value, input int mode, input bit accepted,
                             input int stall_pct, input bit chain, input int nvalue, input int nmode);
        int       idx;
        int       guard;
        logic     exp_last;
        logic     exp_rdy;
        logic [31:0] exp_chunk;
        if (!accepted) begin
            @(negedge clk);
            bus_a.valid_i = 1'b1;
            bus_a.value_i = 7'(value);
            bus_a.mode_i  = unary_mode_e'(mode[1:0]);
            bus_a.ready_i = 1'b0;
            #1;
            checks++;
            if (bus_a.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL %s accept ready_o got %b exp 1", tag, bus_a.ready_o);
            end
            @(posedge clk);
        end
        idx   = 0;
        guard = 0;
        while (idx < NCH_A && guard < 64) begin
            @(negedge clk);
            guard++;
            bus_a.valid_i = 1'b0;
            bus_a.ready_i = ($urandom_range(99) >= stall_pct);
            exp_last      = (idx == NCH_A - 1);
            exp_rdy       = exp_last && bus_a.ready_i;
            if (chain && exp_rdy) begin
                bus_a.valid_i = 1'b1;
                bus_a.value_i = 7'(nvalue);
                bus_a.mode_i  = unary_mode_e'(nmode[1:0]);
            end
            exp_chunk = ref_chunk(value, mode, idx, 128);
            #1;
            checks++;
            if (bus_a.valid_o !== 1'b1 || bus_a.chunk_idx_o !== 2'(idx) || bus_a.last_o !== exp_last
                || bus_a.chunk_o !== exp_chunk || bus_a.ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL %s beat v=%0d m=%0d got valid=%b idx=%0d last=%b chunk=%h ready=%b exp valid=1 idx=%0d last=%b chunk=%h ready=%b",
                         tag, value, mode, bus_a.valid_o, bus_a.chunk_idx_o, bus_a.last_o, bus_a.chunk_o,
                         bus_a.ready_o, idx, exp_last, exp_chunk, exp_rdy);
            end
            @(posedge clk);
            if (bus_a.ready_i) idx++;
        end
        if (idx < NCH_A) begin
            errors++;
            $display("FAIL %s burst_timeout beats got %0d exp %0d", tag, idx, NCH_A);
        end
        $display("burst %s value=%0d mode=%0d cycles=%0d chained=%0d", tag, value, mode, guard, chain);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1 || bus_a.chunk_idx_o !== 2'd0
            || bus_a.last_o !== 1'b0 || bus_a.chunk_o !== 32'h0) begin
            errors++;
            $display("FAIL reset got valid=%b ready=%b idx=%0d last=%b chunk=%h exp 0 1 0 0 0",
                     bus_a.valid_o, bus_a.ready_o, bus_a.chunk_idx_o, bus_a.last_o, bus_a.chunk_o);
        end
        rst = 1'b0;
        // clear alone in IDLE, then clear colliding with an offered input
        clear_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.valid_i = 1'b1;
        bus_a.value_i = 7'd9;
        #1;
        checks++;
        if (bus_a.ready_o !== 1'b0 || bus_a.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_valid got ready=%b valid=%b exp 0 0", bus_a.ready_o, bus_a.valid_o);
        end
        @(posedge clk);
        @(negedge clk);
        clear_a = 1'b0;
        bus_a.valid_i = 1'b0;
        #1;
        checks++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1 || bus_a.chunk_idx_o !== 2'd0) begin
            errors++;
            $display("FAIL clear_idle got valid=%b ready=%b idx=%0d exp 0 1 0",
                     bus_a.valid_o, bus_a.ready_o, bus_a.chunk_idx_o);
        end
        $display("reset/clear idle sequence done");
    endtask

    task automatic test_vectors();
        int          vals  [4] = '{0, 40, 40, 127};
        int          modes [4] = '{0, 0, 1, 2};
        logic [31:0] exp_c [4][4] = '{
            '{32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000},
            '{32'hFFFFFFFF, 32'h000001FF, 32'h00000000, 32'h00000000},
            '{32'h00000000, 32'hFFFFFE00, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000}};
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            bus_a.valid_i = 1'b1;
            bus_a.value_i = 7'(vals[r]);
            bus_a.mode_i  = unary_mode_e'(2'(modes[r]));
            bus_a.ready_i = 1'b1;
            @(posedge clk);
            for (int b = 0; b < NCH_A; b++) begin
                @(negedge clk);
                bus_a.valid_i = 1'b0;
                #1;
                checks++;
                if (bus_a.valid_o !== 1'b1 || bus_a.chunk_o !== exp_c[r][b] || bus_a.chunk_idx_o !== 2'(b)
                    || bus_a.last_o !== (b == NCH_A - 1)) begin
                    errors++;
                    $display("FAIL vector r%0d b%0d got valid=%b chunk=%h idx=%0d last=%b exp chunk=%h idx=%0d",
                             r, b, bus_a.valid_o, bus_a.chunk_o, bus_a.chunk_idx_o, bus_a.last_o, exp_c[r][b], b);
                end
                @(posedge clk);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL vector_end r%0d got valid=%b ready=%b exp 0 1", r, bus_a.valid_o, bus_a.ready_o);
            end
            $display("vector value=%0d mode=%0d done", vals[r], modes[r]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_c [4] = '{32'hFFFFFFFF, 32'h000001FF, 32'h0, 32'h0};
        int          b;
        int          stalls;
        @(negedge clk);
        bus_a.valid_i = 1'b1;
        bus_a.value_i = 7'd40;
        bus_a.mode_i  = UNARY_THERMO;
        bus_a.ready_i = 1'b1;
        @(posedge clk);
        b      = 0;
        stalls = 0;
        while (b < NCH_A) begin
            @(negedge clk);
            bus_a.valid_i = 1'b0;
            bus_a.ready_i = !(b == 1 && stalls < 3);
            if (b == NCH_A - 1) begin
                bus_a.valid_i = 1'b1;
                bus_a.value_i = 7'd5;
                bus_a.mode_i  = UNARY_THERMO;
            end
            #1;
            checks++;
            if (bus_a.valid_o !== 1'b1 || bus_a.chunk_o !== exp_c[b] || bus_a.chunk_idx_o !== 2'(b)
                || bus_a.last_o !== (b == NCH_A - 1) || bus_a.ready_o !== (b == NCH_A - 1)) begin
                errors++;
                $display("FAIL backpressure b%0d stall%0d got chunk=%h idx=%0d last=%b ready=%b exp chunk=%h idx=%0d",
                         b, stalls, bus_a.chunk_o, bus_a.chunk_idx_o, bus_a.last_o, bus_a.ready_o, exp_c[b], b);
            end
            @(posedge clk);
            if (bus_a.ready_i) b++;
            else stalls++;
        end
        $display("backpressure value=40 stalls=%0d done", stalls);
        run_burst("chained5", 5, 0, 1'b1, 0, 1'b0, 0, 0);
    endtask

    task automatic test_clear();
        @(negedge clk);
        bus_a.valid_i = 1'b1;
        bus_a.value_i = 7'd90;
        bus_a.mode_i  = UNARY_THERMO_INV;
        bus_a.ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear_a       = 1'b1;
        bus_a.ready_i = 1'b0;
        #1;
        checks++;
        if (bus_a.chunk_idx_o !== 2'd2 || bus_a.valid_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre got idx=%0d valid=%b exp 2 1", bus_a.chunk_idx_o, bus_a.valid_o);
        end
        @(posedge clk);
        @(negedge clk);
        clear_a = 1'b0;
        #1;
        checks++;
        if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1 || bus_a.chunk_idx_o !== 2'd0) begin
            errors++;
            $display("FAIL clear_post got valid=%b ready=%b idx=%0d exp 0 1 0",
                     bus_a.valid_o, bus_a.ready_o, bus_a.chunk_idx_o);
        end
        $display("clear at idx 2 done");
        run_burst("post_clear", 77, 2, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus_a.valid_i = 1'b1;
        bus_a.value_i = 7'd64;
        bus_a.mode_i  = UNARY_ONEHOT;
        bus_a.ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus_a.valid_o !== 1'b0 || bus_a.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid cycle%0d got valid=%b ready=%b exp 0 1", k, bus_a.valid_o, bus_a.ready_o);
            end
            @(negedge clk);
        end
        $display("reset mid-burst done");
    endtask

    task automatic test_random();
        int v;
        int m;
        int nv;
        int nm;
        bit chain;
        bit acc;
        v   = $urandom_range(127);
        m   = $urandom_range(3);
        acc = 1'b0;
        for (int n = 0; n < 24; n++) begin
            nv    = $urandom_range(127);
            nm    = $urandom_range(3);
            chain = (n < 23) && ($urandom_range(1) == 1);
            run_burst("random", v, m, acc, 30, chain, nv, nm);
            acc = chain;
            v   = nv;
            m   = nm;
        end
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        bus_a.ready_i = 1'b0;
        #1;
        checks++;
        if (bus_a.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL random_end got valid=%b exp 0", bus_a.valid_o);
        end
    endtask

    task automatic test_narrow();
        int vals  [5] = '{100, 100, 100, 10, 63};
        int modes [5] = '{0, 2, 3, 0, 1};
        logic [31:0] exp_chunk;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            bus_b.valid_i = 1'b1;
            bus_b.value_i = 7'(vals[r]);
            bus_b.mode_i  = unary_mode_e'(2'(modes[r]));
            bus_b.ready_i = 1'b1;
            @(posedge clk);
            for (int b = 0; b < NCH_B; b++) begin
                @(negedge clk);
                bus_b.valid_i = 1'b0;
                exp_chunk = ref_chunk(vals[r], modes[r], b, 64);
                #1;
                checks++;
                if (bus_b.valid_o !== 1'b1 || bus_b.chunk_o !== exp_chunk || bus_b.chunk_idx_o !== 1'(b)
                    || bus_b.last_o !== (b == NCH_B - 1)) begin
                    errors++;
                    $display("FAIL narrow v=%0d m=%0d b%0d got valid=%b chunk=%h idx=%0d last=%b exp chunk=%h",
                             vals[r], modes[r], b, bus_b.valid_o, bus_b.chunk_o, bus_b.chunk_idx_o,
                             bus_b.last_o, exp_chunk);
                end
                @(posedge clk);
            end
            $display("narrow value=%0d mode=%0d done", vals[r], modes[r]);
        end
    endtask

    initial begin
        rst           = 1'b1;
        clear_a       = 1'b0;
        clear_b       = 1'b0;
        bus_a.valid_i = 1'b0;
        bus_a.value_i = '0;
        bus_a.mode_i  = UNARY_THERMO;
        bus_a.ready_i = 1'b0;
        bus_b.valid_i = 1'b0;
        bus_b.value_i = '0;
        bus_b.mode_i  = UNARY_THERMO;
        bus_b.ready_i = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_clear();
        test_rst_mid();
        test_random();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
